// File: rtl/ttc_pkg.sv
// rtl/ttc_pkg.sv - shared states and limits for the truth table checker
package ttc_pkg;

  localparam int N_IN_MAX  = 8;
  localparam int DWELL_MIN = 2;
  localparam int DWELL_MAX = 65535;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } ttc_state_e;

endpackage

// File: rtl/ttc_dwell_counter.sv
// rtl/ttc_dwell_counter.sv - per-vector hold counter, terminal count at DWELL-2
module ttc_dwell_counter #(
  parameter int DWELL = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign tc = (count == 16'(DWELL - 2));

endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - sweeps all input vectors and checks a combinational DUT; TTC_STOP_ON_FAIL_EN ends the sweep at the first mismatch
module truth_table_checker
  import ttc_pkg::*;
#(
  parameter int                 N_IN  = 3,
  parameter int                 DWELL = 20,
  parameter logic [2**N_IN-1:0] EXP   = 8'b1110_1000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            dut_f,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail
);

  generate
    if (N_IN < 1 || N_IN > N_IN_MAX) begin : g_bad_n_in
      $error("truth_table_checker: N_IN out of range 1..8");
    end
    if (DWELL < DWELL_MIN || DWELL > DWELL_MAX) begin : g_bad_dwell
      $error("truth_table_checker: DWELL out of range 2..65535");
    end
  endgenerate

  localparam logic [N_IN-1:0] STIM_LAST = '1;

  ttc_state_e    state;
  logic          dwell_clear;
  logic          dwell_en;
  logic          dwell_tc;
  logic          mismatch;
  logic          stop_now;
  logic [N_IN:0] err_next;

  assign mismatch = (dut_f != EXP[stim]);
  assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

`ifdef TTC_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // The counter restarts on every entry into APPLY and freezes at terminal count.
  always_comb begin
    dwell_clear = 1'b0;
    dwell_en    = 1'b0;
    if (state == SAMPLE) begin
      dwell_clear = 1'b1;
    end else if ((state == IDLE || state == DONE) && start) begin
      dwell_clear = 1'b1;
    end
    if (state == APPLY && !dwell_tc) begin
      dwell_en = 1'b1;
    end
  end

  ttc_dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (dwell_clear),
    .enable (dwell_en),
    .tc     (dwell_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            stim       <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
          end
        end
        APPLY: begin
          if (dwell_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_next;
            if (err_count == '0) begin
              first_fail <= stim;
            end
          end
          if (stop_now || stim == STIM_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state <= APPLY;
            stim  <= stim + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - directed checks of truth_table_checker across three configurations
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // main instance: majority function, optional faults at stim 3 and 6
  logic       start_m = 1'b0;
  logic       inject = 1'b0;
  logic       f_m;
  logic [2:0] stim_m;
  logic       busy_m, done_m, pass_m;
  logic [3:0] err_m;
  logic [2:0] ff_m;

  assign f_m = ((stim_m[2] & stim_m[1]) | (stim_m[2] & stim_m[0]) | (stim_m[1] & stim_m[0]))
               ^ (inject && (stim_m == 3'd3 || stim_m == 3'd6));

  truth_table_checker #(.N_IN(3), .DWELL(20), .EXP(8'hE8)) u_dut_m (
    .clk(clk), .reset_n(reset_n), .start(start_m), .dut_f(f_m),
    .stim(stim_m), .busy(busy_m), .done(done_m), .pass(pass_m),
    .err_count(err_m), .first_fail(ff_m)
  );

  // all-ones expectation against a DUT tied low
  logic       start_z = 1'b0;
  logic [2:0] stim_z;
  logic       busy_z, done_z, pass_z;
  logic [3:0] err_z;
  logic [2:0] ff_z;

  truth_table_checker #(.N_IN(3), .DWELL(20), .EXP(8'hFF)) u_dut_z (
    .clk(clk), .reset_n(reset_n), .start(start_z), .dut_f(1'b0),
    .stim(stim_z), .busy(busy_z), .done(done_z), .pass(pass_z),
    .err_count(err_z), .first_fail(ff_z)
  );

  // smallest legal configuration: inverter
  logic       start_n = 1'b0;
  logic [0:0] stim_n;
  logic       busy_n, done_n, pass_n;
  logic [1:0] err_n;
  logic [0:0] ff_n;

  truth_table_checker #(.N_IN(1), .DWELL(2), .EXP(2'b01)) u_dut_n (
    .clk(clk), .reset_n(reset_n), .start(start_n), .dut_f(~stim_n[0]),
    .stim(stim_n), .busy(busy_n), .done(done_n), .pass(pass_n),
    .err_count(err_n), .first_fail(ff_n)
  );

`ifdef TTC_STOP_ON_FAIL_EN
  localparam int T_FAULT = 80;
  localparam int E_FAULT = 2 - 1;
  localparam int S_FAULT = 3;
  localparam int T_ZERO  = 20;
  localparam int E_ZERO  = 1;
  localparam int S_ZERO  = 0;
`else
  localparam int T_FAULT = 160;
  localparam int E_FAULT = 2;
  localparam int S_FAULT = 7;
  localparam int T_ZERO  = 160;
  localparam int E_ZERO  = 8;
  localparam int S_ZERO  = 7;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_m(output int n);
    n = 0;
    while (!done_m && n < 1000) begin tick(); n++; end
  endtask

  task automatic wait_z(output int n);
    n = 0;
    while (!done_z && n < 1000) begin tick(); n++; end
  endtask

  task automatic wait_n(output int n);
    n = 0;
    while (!done_n && n < 1000) begin tick(); n++; end
  endtask

  int cyc;
  int first_done;
  int second_done;

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_pass", pass_m, 0);
    check("rst_err", err_m, 0);
    check("rst_stim", stim_m, 0);
    check("rst_ff", ff_m, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // clean majority sweep
    start_m = 1'b1; tick(); start_m = 1'b0;
    check("s1_busy", busy_m, 1);
    check("s1_stim0", stim_m, 0);
    wait_m(cyc);
    check("s1_cycles", cyc, 160);
    check("s1_pass", pass_m, 1);
    check("s1_err", err_m, 0);
    check("s1_stim", stim_m, 7);
    check("s1_busy_end", busy_m, 0);
    repeat (5) tick();
    check("s1_done_hold", done_m, 1);

    // faults at stim 3 and 6
    inject = 1'b1;
    start_m = 1'b1; tick(); start_m = 1'b0;
    check("s2_done_clr", done_m, 0);
    wait_m(cyc);
    check("s2_cycles", cyc, T_FAULT);
    check("s2_err", err_m, E_FAULT);
    check("s2_ff", ff_m, 3);
    check("s2_pass", pass_m, 0);
    check("s2_stim", stim_m, S_FAULT);
    repeat (10) tick();
    check("s2_err_hold", err_m, E_FAULT);
    check("s2_ff_hold", ff_m, 3);

    // every vector wrong
    start_z = 1'b1; tick(); start_z = 1'b0;
    wait_z(cyc);
    check("s3_cycles", cyc, T_ZERO);
    check("s3_err", err_z, E_ZERO);
    check("s3_ff", ff_z, 0);
    check("s3_pass", pass_z, 0);
    check("s3_stim", stim_z, S_ZERO);

    // single-input inverter, DWELL=2
    start_n = 1'b1; tick(); start_n = 1'b0;
    wait_n(cyc);
    check("s6_cycles", cyc, 4);
    check("s6_pass", pass_n, 1);
    check("s6_err", err_n, 0);
    check("s6_stim", stim_n, 1);

    // start held high: back-to-back sweeps, results cleared at restart
    first_done = -1;
    second_done = -1;
    start_m = 1'b1; tick();
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (c == 50) begin
        check("s5_busy_mid", busy_m, 1);
        check("s5_stim_mid", stim_m, 2);
      end
      if (first_done > 0 && c == first_done + 1) begin
        check("s5_restart_busy", busy_m, 1);
        check("s5_restart_done", done_m, 0);
        check("s5_restart_err", err_m, 0);
        check("s5_restart_stim", stim_m, 0);
      end
      if (done_m && first_done < 0) first_done = c;
      else if (done_m && second_done < 0 && c > first_done + 1) second_done = c;
    end
    start_m = 1'b0;
    check("s5_first_done", first_done, T_FAULT);
    check("s5_second_done", second_done, 2 * T_FAULT + 1);
    inject = 1'b0;
    reset_n = 1'b0; repeat (2) tick(); reset_n = 1'b1; repeat (2) tick();

    // asynchronous reset in the middle of vector 5
    start_m = 1'b1; tick(); start_m = 1'b0;
    repeat (107) tick();
    check("s4_stim_pre", stim_m, 5);
    #2 reset_n = 1'b0;
    #1;
    check("s4_busy", busy_m, 0);
    check("s4_stim", stim_m, 0);
    check("s4_done", done_m, 0);
    check("s4_err", err_m, 0);
    check("s4_pass", pass_m, 0);
    repeat (2) tick();
    #2 reset_n = 1'b1;
    repeat (60) tick();
    check("s4_idle_busy", busy_m, 0);
    check("s4_idle_done", done_m, 0);
    check("s4_idle_stim", stim_m, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter N_IN, default 3, meaning the DUT input count (legal range 1..8).
REQ-002 SHALL have parameter DWELL, default 20, meaning the clock cycles each vector is held (legal range 2..65535).
REQ-003 SHALL have parameter EXP, width 2**N_IN, default 8'b1110_1000, meaning the expected truth table: bit i is the expected f for input value i.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a level sampled each edge that requests a sweep.
REQ-007 SHALL have port dut_f, input, 1 bit: the combinational DUT response to stim.
REQ-008 SHALL have port stim, output, N_IN bits: the applied input vector, with bit N_IN-1 as MSB (a).
REQ-009 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1 bit: high once the sweep is complete; held until the next start.
REQ-011 SHALL have port pass, output, 1 bit: high when done=1 and err_count=0.
REQ-012 SHALL have port err_count, output, N_IN+1 bits: the number of mismatching vectors (cannot overflow).
REQ-013 SHALL have port first_fail, output, N_IN bits: the stim value of the first mismatch; valid when err_count!=0.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, SAMPLE, DONE.
REQ-015 SHALL leave IDLE for APPLY on the edge where start=1, setting busy=1, stim=0, err_count=0, first_fail=0, dwell=0 on that edge.
REQ-016 SHALL hold stim constant in APPLY for DWELL-1 cycles (dwell counts 0..DWELL-2), then enter SAMPLE.
REQ-017 SHALL, in SAMPLE (one cycle), compare dut_f against EXP[stim]; on mismatch, increment err_count, and load first_fail if err_count was 0.
REQ-018 SHALL, on leaving SAMPLE with stim!=2**N_IN-1, increment stim, clear dwell, and re-enter APPLY.
REQ-019 SHALL, on leaving SAMPLE with stim=2**N_IN-1, enter DONE with busy=0 and done=1, and hold stim at the all-ones value.
REQ-020 SHALL make done rise exactly 2**N_IN*DWELL cycles after the start edge.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL, on start=1 in DONE, clear done/pass and restart exactly as REQ-015; a held start SHALL give back-to-back sweeps.
REQ-023 SHALL keep err_count, first_fail and pass stable in DONE until the restart.

Reset
REQ-024 SHALL, on reset_n=0, immediately force the FSM to IDLE and set stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0 and dwell=0.
REQ-025 SHALL, on a mid-sweep reset, abandon the sweep with no partial result retained; the first sweep after release SHALL need a new start.

Configuration
REQ-026 SHALL, with TTC_STOP_ON_FAIL_EN defined, go from SAMPLE directly to DONE on the first mismatch, with err_count=1, pass=0, and stim held at the failing vector.
REQ-027 SHALL, without TTC_STOP_ON_FAIL_EN, always sweep all 2**N_IN vectors and count every mismatch.

Structure
REQ-028 SHALL take the FSM state enum typedef and the constants N_IN_MAX=8 and DWELL_MIN=2 from shared package ttc_pkg.
REQ-029 SHALL implement the dwell timing as sub-module ttc_dwell_counter, which has clear/enable inputs and a terminal-count output at DWELL-2.
REQ-030 SHALL fail elaboration when N_IN or DWELL is outside the legal range.

Verification
REQ-031 SHALL cover: N_IN=3, DWELL=20, EXP=8'hE8, dut_f=majority(stim), one start pulse -> done at cycle 160 after start, pass=1, err_count=0, stim=3'b111.
REQ-032 SHALL cover: same setup with dut_f forced wrong at stim=3 and stim=6 -> err_count=2, first_fail=3, pass=0 (macro off); with TTC_STOP_ON_FAIL_EN -> done at cycle 80, stim=3, err_count=1.
REQ-033 SHALL cover: dut_f tied to 0 with EXP=8'hFF -> err_count=8 (full-width count), first_fail=0.
REQ-034 SHALL cover: reset_n pulsed low at stim=5 mid-dwell -> all outputs 0 asynchronously, no sweep without a new start.
REQ-035 SHALL cover: start held high for 400 cycles -> start ignored while busy, second sweep begins the cycle after the first done, results cleared at the restart.
REQ-036 SHALL cover: N_IN=1, DWELL=2, EXP=2'b01, dut_f=~stim -> done 4 cycles after start, pass=1.
